instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Write side of the CPU instruction memory. Accepts a byte stream over a valid/ready handshake, packs the bytes little-endian into 32-bit words, and writes them sequentially into a 256×32 instruction RAM from word 0. It also provides the word-indexed combinational read port that the fetch stage drives with `program_counter`. While a load is in progress it holds the CPU in stall.

## Interface
Parameters:
- `DEPTH`, 256: number of 32-bit instruction words.
- `ADDR_W`, 8: word address width, equal to log2(DEPTH).

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_start` in 1: single-cycle request to begin a load.
- `load_len` in 9: number of words to load, legal range 1..DEPTH; sampled only on an accepted `load_start`.
- `byte_valid` in 1: source has a byte on `byte_data`.
- `byte_data` in 8: stream byte.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `program_counter` in 32: word index from the fetch stage.
- `instruction` out 32: memory word at `program_counter`.
- `loading` out 1: a load is in progress.
- `cpu_stall` out 1: identical to `loading`.
- `load_done` out 1: last load completed; sticky.
- `err` out 1: single-cycle pulse when a request is rejected.

## Operation
- FSM states: IDLE, LOAD, DONE. Reset state is IDLE.
- IDLE or DONE, `load_start`=1, `load_len` in 1..DEPTH:
  - latch the length;
  - clear the word address and byte count;
  - clear `load_done`;
  - go to LOAD.
- IDLE or DONE, `load_start`=1, `load_len`=0 or `load_len`>DEPTH: pulse `err`; stay in the current state; `load_done` is unchanged.
- LOAD, `load_start`=1: ignored and `err` pulses. Byte traffic in the same cycle is still processed normally.
- `byte_ready`=1 only in LOAD. A byte transfers when `byte_valid` and `byte_ready` are both 1 on a rising edge.
- Byte k (k=0..3) of a word occupies bits [8k+7:8k]; the first byte received is the least significant.
- Bytes 0–2 go into a 24-bit assembly register.
- On byte 3: write `mem[waddr] <= {byte_data, asm[23:0]}`, increment `waddr`, and reset the byte count.
- If that write was word `len-1`: go to DONE and set `load_done`=1.
- DONE behaves like IDLE, except that `load_done` is held at 1.
- Read port:
  - `instruction = mem[program_counter[ADDR_W-1:0]]` when `program_counter` < DEPTH;
  - 32'h0 otherwise;
  - combinational, with no enable.
- Memory contents are not reset. Words not written by a load keep their previous or initial contents.
- `loading` = `cpu_stall` = (state==LOAD).

## Timing
- Reset values:
  - `byte_ready`=0, `loading`=0, `cpu_stall`=0, `load_done`=0, `err`=0.
  - `waddr`=0, byte count=0, assembly register=0.
  - `instruction` follows memory and `program_counter`.
- `load_start` at edge N: `byte_ready`=1 and `loading`=1 from cycle N+1 onward.
- A byte can be accepted on every cycle in LOAD. Throughput is 1 byte/clk, so 4 clk per word at full rate.
- Write timing:
  - the write occurs at the edge that accepts byte 3;
  - the new word is visible on `instruction` from the following cycle;
  - in the same cycle it still shows the old contents.
- Final word accepted at edge M:
  - `loading`=0, `byte_ready`=0, `load_done`=1 from cycle M+1;
  - the byte presented at edge M+1 is not accepted.
- `err` is high for exactly one cycle, the cycle after the rejected request.
- A `byte_valid` gap leaves the byte count and assembly register frozen.
- Wrap: `load_len`=DEPTH writes words 0..255. `waddr` never wraps past `len-1`.
- `rst_n` low mid-load:
  - immediate return to IDLE; partial word discarded;
  - words already written remain in memory;
  - `load_done`=0.

## Structure
- A shared package holds:
  - the FSM state enum (IDLE, LOAD, DONE);
  - `INSTR_W`=32, `BYTE_W`=8, `BYTES_PER_WORD`=4;
  - the default `DEPTH`.
- One sub-module, `instr_ram`:
  - one synchronous write port (`we`, `waddr`, `wdata`);
  - one asynchronous read port (`raddr`, `rdata`).
- The loader FSM, byte counter, assembly register and range check on the read address sit in `instr_mem_loader`.

## Test plan
- Load with `load_len`=2, bytes 78 56 34 12 EF BE AD DE at full rate:
  - `mem[0]`=32'h12345678, `mem[1]`=32'hDEADBEEF;
  - `load_done` rises 1 cycle after the 8th byte;
  - `loading` is high for exactly 8 cycles.
- Same load with `byte_valid` toggling 1/0: identical memory contents; the load takes 16 cycles; the assembly register holds its value across the gaps.
- `load_len`=0, then 257:
  - `err` pulses once for each request;
  - state stays IDLE; `byte_ready` stays 0; memory is unchanged.
- `load_start` issued mid-load: `err` pulses and the load completes normally to `load_len` words.
- `rst_n` asserted after 6 bytes of a 2-word load:
  - outputs return to reset values asynchronously;
  - `mem[0]` holds the new word and `mem[1]` holds its old value.
- After loading 256 words, read checks:
  - `program_counter`=255 returns the last word written;
  - `program_counter`=256 returns 32'h0;
  - `program_counter`=32'hFFFFFFFF returns 32'h0.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader_pkg
// Description : Shared types and constants for the instruction memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_mem_loader_pkg;

    localparam int INSTR_W        = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);
    localparam int DEFAULT_DEPTH  = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_ram.sv
`default_nettype none
// ============================================================================
// Module      : instr_ram
// Description : Instruction RAM, one synchronous write port and one
//               asynchronous read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_ram
    import instr_mem_loader_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // Write a full word on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader
// Description : Packs a little-endian byte stream into 32-bit words and writes
//               them sequentially into the instruction RAM from word 0.
//               Stalls the CPU while a load is running and exposes the
//               fetch-side read port.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_start,
    input  logic [8:0]         load_len,
    input  logic               byte_valid,
    input  logic [BYTE_W-1:0]  byte_data,
    output logic               byte_ready,
    input  logic [31:0]        program_counter,
    output logic [INSTR_W-1:0] instruction,
    output logic               loading,
    output logic               cpu_stall,
    output logic               load_done,
    output logic               err
);

    localparam int ASM_W = (BYTES_PER_WORD - 1) * BYTE_W;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W-1:0]   waddr;
    logic [CNT_W-1:0]    byte_cnt;
    logic [ASM_W-1:0]    asm_q;

    logic                len_ok;
    logic                start_ok;
    logic                start_bad;
    logic                byte_fire;
    logic                word_fire;
    logic                last_word;
    logic [INSTR_W-1:0]  mem_wdata;
    logic [INSTR_W-1:0]  mem_rdata;

    assign len_ok    = (load_len != '0) && (32'(load_len) <= 32'(DEPTH));
    assign start_ok  = load_start && len_ok && (state != ST_LOAD);
    // A request while loading is always rejected, whatever its length.
    assign start_bad = load_start && ((state == ST_LOAD) || !len_ok);
    assign byte_fire = byte_valid && (state == ST_LOAD);
    assign word_fire = byte_fire && (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));
    assign last_word = word_fire && ({1'b0, waddr} == (len_q - 1'b1));
    assign mem_wdata = {byte_data, asm_q};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/status outputs; DONE accepts requests like IDLE.
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        loading    = 1'b0;
        cpu_stall  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                byte_ready = 1'b1;
                loading    = 1'b1;
                cpu_stall  = 1'b1;
                if (last_word) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Length latch, write address, byte counter and assembly register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            waddr    <= '0;
            byte_cnt <= '0;
            asm_q    <= '0;
        end else if (start_ok) begin
            len_q    <= load_len[ADDR_W:0];
            waddr    <= '0;
            byte_cnt <= '0;
        end else if (byte_fire) begin
            if (word_fire) begin
                byte_cnt <= '0;
                waddr    <= waddr + 1'b1;
            end else begin
                asm_q[byte_cnt*BYTE_W +: BYTE_W] <= byte_data;
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

    // Sticky completion flag and one-cycle rejection pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= start_bad;
            if (start_ok) begin
                load_done <= 1'b0;
            end else if (last_word) begin
                load_done <= 1'b1;
            end
        end
    end

    instr_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (word_fire),
        .waddr (waddr),
        .wdata (mem_wdata),
        .raddr (program_counter[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

    // Addresses beyond the RAM read as zero.
    assign instruction = (program_counter < 32'(DEPTH)) ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_loader
// Description : Self-checking bench for instr_mem_loader with a word-array
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic [8:0]  load_len = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic [31:0] program_counter = '0;
    logic [31:0] instruction;
    logic        loading;
    logic        cpu_stall;
    logic        load_done;
    logic        err;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] ref_mem [256];
    logic [7:0]  tb_bytes [$];

    instr_mem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_start      (load_start),
        .load_len        (load_len),
        .byte_valid      (byte_valid),
        .byte_data       (byte_data),
        .byte_ready      (byte_ready),
        .program_counter (program_counter),
        .instruction     (instruction),
        .loading         (loading),
        .cpu_stall       (cpu_stall),
        .load_done       (load_done),
        .err             (err)
    );

    always #5 clk = ~clk;

    // Stream of random bytes for nwords words.
    task automatic fill_random(input int nwords);
        tb_bytes.delete();
        for (int i = 0; i < 4 * nwords; i++) tb_bytes.push_back(8'($urandom));
    endtask

    // Model: word w is bytes 4w..4w+3, first byte least significant.
    task automatic commit_words(input int nwords);
        for (int w = 0; w < nwords; w++)
            ref_mem[w] = {tb_bytes[4*w+3], tb_bytes[4*w+2], tb_bytes[4*w+1], tb_bytes[4*w]};
    endtask

    // Drive a load request and stream tb_bytes (up to max_bytes).
    // mode: 0 full rate, 1 valid toggles starting low, 2 random gaps.
    task automatic do_load(input int len, input int mode, input int max_bytes, input int restart_at,
                           output int load_cyc, output logic done_early, output logic done_after,
                           output logic loading_after, output logic ready_after, output int err_cnt,
                           output logic [31:0] old_word, output logic [31:0] new_word,
                           output logic timeout);
        int   idx = 0;
        int   cyc = 0;
        int   nb;
        logic phase = 1'b0;
        logic v;
        logic rdy;
        logic cap = 1'b0;
        logic restarted = 1'b0;
        nb = (max_bytes < tb_bytes.size()) ? max_bytes : tb_bytes.size();
        load_cyc = 0; err_cnt = 0; timeout = 1'b0; done_early = 1'b0;
        old_word = '0; new_word = '0;
        @(negedge clk);
        load_start = 1'b1;
        load_len   = len[8:0];
        @(negedge clk);
        load_start = 1'b0;
        while (idx < nb) begin
            if (cap) begin new_word = instruction; cap = 1'b0; end
            if (err) err_cnt++;
            if (loading) load_cyc++;
            rdy = byte_ready;
            load_start = 1'b0;
            if (!restarted && idx == restart_at) begin
                load_start = 1'b1;
                load_len   = 9'd1;
                restarted  = 1'b1;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = phase;
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            phase = ~phase;
            byte_valid = v;
            byte_data  = v ? tb_bytes[idx] : 8'($urandom);
            if (v && rdy && idx == 3) begin old_word = instruction; cap = 1'b1; end
            if (v && rdy && idx == nb - 1) done_early = load_done;
            @(negedge clk);
            if (v && rdy) idx++;
            cyc++;
            if (cyc > 5000) begin timeout = 1'b1; break; end
        end
        load_start = 1'b0;
        byte_valid = 1'b0;
        if (cap) new_word = instruction;
        if (err) err_cnt++;
        done_after    = load_done;
        loading_after = loading;
        ready_after   = byte_ready;
        if (idx == tb_bytes.size()) begin
            // Extra byte after completion must not be taken.
            byte_valid = 1'b1;
            byte_data  = 8'hA5;
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks += 5;
        if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_byte_ready: got %b expected 0", byte_ready); end
        if (loading !== 1'b0)    begin n_fail++; $display("FAIL reset_loading: got %b expected 0", loading); end
        if (cpu_stall !== 1'b0)  begin n_fail++; $display("FAIL reset_cpu_stall: got %b expected 0", cpu_stall); end
        if (load_done !== 1'b0)  begin n_fail++; $display("FAIL reset_load_done: got %b expected 0", load_done); end
        if (err !== 1'b0)        begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_load();
        int lc, ec; logic de, da, la, ra, to; logic [31:0] ow, nw;
        fill_random(256);
        do_load(256, 2, 1 << 20, -1, lc, de, da, la, ra, ec, ow, nw, to);
        commit_words(256);
        n_checks += 4;
        if (to !== 1'b0) begin n_fail++; $display("FAIL full_timeout: load did not finish"); end
        if (da !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b expected 1", da); end
        if (la !== 1'b0) begin n_fail++; $display("FAIL full_loading_after: got %b expected 0", la); end
        if (ec != 0)     begin n_fail++; $display("FAIL full_err: got %0d pulses expected 0", ec); end
        for (int w = 0; w < 256; w++) begin
            program_counter = w; #1;
            n_checks++;
            if (instruction !== ref_mem[w]) begin
                n_fail++; $display("FAIL full_read[%0d]: got %h expected %h", w, instruction, ref_mem[w]);
            end
        end
        program_counter = 32'd256; #1; n_checks++;
        if (instruction !== 32'h0) begin n_fail++; $display("FAIL read_pc256: got %h expected 0", instruction); end
        program_counter = 32'hFFFF_FFFF; #1; n_checks++;
        if (instruction !== 32'h0) begin n_fail++; $display("FAIL read_pc_max: got %h expected 0", instruction); end
        program_counter = $urandom_range(257, 100000); #1; n_checks++;
        if (instruction !== 32'h0) begin n_fail++; $display("FAIL read_pc_high: got %h expected 0", instruction); end
        program_counter = 32'd0;
    endtask

    task automatic load_known_stream();
        tb_bytes.delete();
        tb_bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    endtask

    task automatic check_words(input string name, input int nwords);
        for (int w = 0; w < nwords; w++) begin
            program_counter = w; #1; n_checks++;
            if (instruction !== ref_mem[w]) begin
                n_fail++; $display("FAIL %s[%0d]: got %h expected %h", name, w, instruction, ref_mem[w]);
            end
        end
        program_counter = 32'd0;
    endtask

    task automatic test_basic();
        int lc, ec; logic de, da, la, ra, to; logic [31:0] ow, nw, old0;
        old0 = ref_mem[0];
        program_counter = 32'd0;
        load_known_stream();
        do_load(2, 0, 1 << 20, -1, lc, de, da, la, ra, ec, ow, nw, to);
        commit_words(2);
        n_checks += 9;
        if (to !== 1'b0)        begin n_fail++; $display("FAIL basic_timeout: load did not finish"); end
        if (lc != 8)            begin n_fail++; $display("FAIL basic_loading_cycles: got %0d expected 8", lc); end
        if (de !== 1'b0)        begin n_fail++; $display("FAIL basic_done_early: got %b expected 0", de); end
        if (da !== 1'b1)        begin n_fail++; $display("FAIL basic_done_after: got %b expected 1", da); end
        if (la !== 1'b0)        begin n_fail++; $display("FAIL basic_loading_after: got %b expected 0", la); end
        if (ra !== 1'b0)        begin n_fail++; $display("FAIL basic_ready_after: got %b expected 0", ra); end
        if (ow !== old0)        begin n_fail++; $display("FAIL basic_old_word: got %h expected %h", ow, old0); end
        if (nw !== 32'h12345678) begin n_fail++; $display("FAIL basic_new_word: got %h expected 12345678", nw); end
        if (ref_mem[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_model_word1: got %h expected deadbeef", ref_mem[1]); end
        check_words("basic_mem", 4);
    endtask

    task automatic test_gaps();
        int lc, ec; logic de, da, la, ra, to; logic [31:0] ow, nw;
        fill_random(2);
        do_load(2, 0, 1 << 20, -1, lc, de, da, la, ra, ec, ow, nw, to);
        commit_words(2);
        load_known_stream();
        do_load(2, 1, 1 << 20, -1, lc, de, da, la, ra, ec, ow, nw, to);
        commit_words(2);
        n_checks += 3;
        if (to !== 1'b0) begin n_fail++; $display("FAIL gaps_timeout: load did not finish"); end
        if (lc != 16)    begin n_fail++; $display("FAIL gaps_loading_cycles: got %0d expected 16", lc); end
        if (da !== 1'b1) begin n_fail++; $display("FAIL gaps_done: got %b expected 1", da); end
        check_words("gaps_mem", 4);
    endtask

    task automatic test_bad_len();
        logic [8:0] lens [3];
        logic       ld;
        lens[0] = 9'd0; lens[1] = 9'd257; lens[2] = 9'($urandom_range(258, 511));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ld = load_done;
            load_start = 1'b1; load_len = lens[i];
            @(negedge clk);
            load_start = 1'b0;
            n_checks += 3;
            if (err !== 1'b1)        begin n_fail++; $display("FAIL bad_len_err[%0d]: got %b expected 1", lens[i], err); end
            if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL bad_len_ready[%0d]: got %b expected 0", lens[i], byte_ready); end
            if (loading !== 1'b0)    begin n_fail++; $display("FAIL bad_len_loading[%0d]: got %b expected 0", lens[i], loading); end
            byte_valid = 1'b1; byte_data = 8'h3C;
            @(negedge clk);
            byte_valid = 1'b0;
            n_checks += 3;
            if (err !== 1'b0)        begin n_fail++; $display("FAIL bad_len_err_width[%0d]: got %b expected 0", lens[i], err); end
            if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL bad_len_ready2[%0d]: got %b expected 0", lens[i], byte_ready); end
            if (load_done !== ld)    begin n_fail++; $display("FAIL bad_len_done[%0d]: got %b expected %b", lens[i], load_done, ld); end
        end
        check_words("bad_len_mem", 4);
    endtask

    task automatic test_start_midload();
        int lc, ec; logic de, da, la, ra, to; logic [31:0] ow, nw;
        fill_random(3);
        do_load(3, 0, 1 << 20, 5, lc, de, da, la, ra, ec, ow, nw, to);
        commit_words(3);
        n_checks += 4;
        if (to !== 1'b0) begin n_fail++; $display("FAIL midstart_timeout: load did not finish"); end
        if (ec != 1)     begin n_fail++; $display("FAIL midstart_err: got %0d pulses expected 1", ec); end
        if (lc != 12)    begin n_fail++; $display("FAIL midstart_loading_cycles: got %0d expected 12", lc); end
        if (da !== 1'b1) begin n_fail++; $display("FAIL midstart_done: got %b expected 1", da); end
        check_words("midstart_mem", 5);
    endtask

    task automatic test_reset_midload();
        int lc, ec; logic de, da, la, ra, to; logic [31:0] ow, nw;
        fill_random(2);
        do_load(2, 0, 6, -1, lc, de, da, la, ra, ec, ow, nw, to);
        commit_words(1);
        n_checks++;
        if (la !== 1'b1) begin n_fail++; $display("FAIL rst_mid_loading_before: got %b expected 1", la); end
        #2 rst_n = 1'b0;
        #1;
        n_checks += 5;
        if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 0", byte_ready); end
        if (loading !== 1'b0)    begin n_fail++; $display("FAIL rst_mid_loading: got %b expected 0", loading); end
        if (cpu_stall !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_stall: got %b expected 0", cpu_stall); end
        if (load_done !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_done: got %b expected 0", load_done); end
        if (err !== 1'b0)        begin n_fail++; $display("FAIL rst_mid_err: got %b expected 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        check_words("rst_mid_mem", 4);
    endtask

    task automatic test_random();
        int lc, ec, len; logic de, da, la, ra, to; logic [31:0] ow, nw;
        for (int it = 0; it < 4; it++) begin
            len = $urandom_range(1, 6);
            fill_random(len);
            do_load(len, 2, 1 << 20, -1, lc, de, da, la, ra, ec, ow, nw, to);
            commit_words(len);
            n_checks += 3;
            if (to !== 1'b0) begin n_fail++; $display("FAIL rand_timeout[%0d]: load did not finish", it); end
            if (da !== 1'b1) begin n_fail++; $display("FAIL rand_done[%0d]: got %b expected 1", it, da); end
            if (ec != 0)     begin n_fail++; $display("FAIL rand_err[%0d]: got %0d expected 0", it, ec); end
            check_words("rand_mem", len + 1);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_basic();
        test_gaps();
        test_bad_len();
        test_start_midload();
        test_reset_midload();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
